// File: rtl/dac_sample_pacer_if.sv
// Producer/modulator-side signal bundle for dac_sample_pacer.
// The master modport is the producer/observer; the slave modport is the pacer.
interface dac_sample_pacer_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_left;
    logic [WIDTH-1:0]       in_right;
    logic [WIDTH-1:0]       out_left;
    logic [WIDTH-1:0]       out_right;
    logic                   out_strobe;
    logic [$clog2(DEPTH):0] level;
    logic                   underrun;
    logic                   clr_underrun;

    modport master (
        output in_valid, in_left, in_right, clr_underrun,
        input  in_ready, out_left, out_right, out_strobe, level, underrun
    );

    modport slave (
        input  in_valid, in_left, in_right, clr_underrun,
        output in_ready, out_left, out_right, out_strobe, level, underrun
    );
endinterface

// File: rtl/dac_sample_pacer.sv
// Stereo PCM FIFO that releases one sample pair every DIV clk27 cycles.
// On an empty tick the last pair is held and a sticky underrun flag is raised.
module dac_sample_pacer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int DIV   = 562
) (
    input logic                clk27,
    input logic                n_rst,
    dac_sample_pacer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int DIV_W = $clog2(DIV);

    logic [DIV_W-1:0]   div_q, div_d;
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [LVL_W-1:0]   lvl_q, lvl_d;
    logic [WIDTH-1:0]   left_q, left_d, right_q, right_d;
    logic               strobe_q, strobe_d;
    logic               und_q, und_d;
    logic [2*WIDTH-1:0] mem [DEPTH];

    logic tick, push, pop, empty, full;

    assign tick  = (div_q == DIV_W'(DIV - 1));
    assign empty = (lvl_q == '0);
    assign full  = (lvl_q == LVL_W'(DEPTH));
    // Both decisions use the registered level, so a push into an empty FIFO
    // cannot satisfy the same tick and a pop cannot raise in_ready early.
    assign push  = bus.in_valid && !full;
    assign pop   = tick && !empty;

    always_comb begin
        div_d    = tick ? '0 : div_q + 1'b1;
        wr_d     = push ? wr_q + 1'b1 : wr_q;
        rd_d     = pop  ? rd_q + 1'b1 : rd_q;
        lvl_d    = lvl_q;
        left_d   = left_q;
        right_d  = right_q;
        strobe_d = pop;
        und_d    = und_q;

        if (push && !pop) begin
            lvl_d = lvl_q + 1'b1;
        end else if (pop && !push) begin
            lvl_d = lvl_q - 1'b1;
        end

        if (pop) begin
            {left_d, right_d} = mem[rd_q];
        end

        if (tick && empty) begin
            und_d = 1'b1;
        end else if (bus.clr_underrun) begin
            und_d = 1'b0;
        end
    end

    always_ff @(posedge clk27 or negedge n_rst) begin
        if (!n_rst) begin
            div_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            lvl_q    <= '0;
            left_q   <= '0;
            right_q  <= '0;
            strobe_q <= 1'b0;
            und_q    <= 1'b0;
        end else begin
            div_q    <= div_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            lvl_q    <= lvl_d;
            left_q   <= left_d;
            right_q  <= right_d;
            strobe_q <= strobe_d;
            und_q    <= und_d;
        end
    end

    // Storage is unreset: pointers and level alone define what is readable.
    always_ff @(posedge clk27) begin
        if (push) begin
            mem[wr_q] <= {bus.in_left, bus.in_right};
        end
    end

    assign bus.in_ready   = !full;
    assign bus.out_left   = left_q;
    assign bus.out_right  = right_q;
    assign bus.out_strobe = strobe_q;
    assign bus.level      = lvl_q;
    assign bus.underrun   = und_q;
endmodule

// File: tb/tb_dac_sample_pacer.sv
// Randomised scoreboard bench for dac_sample_pacer (DIV=4, DEPTH=4).
// A queue-based reference model predicts pops; a negedge monitor compares.
module tb_dac_sample_pacer;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int DIV   = 4;

    logic clk27 = 1'b0;
    logic n_rst = 1'b0;

    dac_sample_pacer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    dac_sample_pacer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV(DIV)) dut (
        .clk27 (clk27),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    always #5 clk27 = ~clk27;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state
    int unsigned      m_cyc;
    logic [31:0]      mq[$];
    logic [31:0]      exp_q[$];
    logic             m_und;
    logic [15:0]      m_l, m_r;
    logic             m_stb;
    logic             m_tick, m_empty, m_acc;
    logic [31:0]      m_p;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    always @(posedge clk27 or negedge n_rst) begin
        if (!n_rst) begin
            m_cyc = 0;
            mq.delete();
            exp_q.delete();
            m_und = 1'b0;
            m_l   = '0;
            m_r   = '0;
            m_stb = 1'b0;
        end else begin
            m_tick  = (m_cyc == DIV - 1);
            m_cyc   = (m_cyc + 1) % DIV;
            m_empty = (mq.size() == 0);
            m_acc   = bus.in_valid && (mq.size() < DEPTH);
            m_stb   = 1'b0;
            if (m_tick && !m_empty) begin
                m_p = mq.pop_front();
                exp_q.push_back(m_p);
                m_l   = m_p[31:16];
                m_r   = m_p[15:0];
                m_stb = 1'b1;
            end
            if (m_tick && m_empty) m_und = 1'b1;
            else if (bus.clr_underrun) m_und = 1'b0;
            if (m_acc) mq.push_back({bus.in_left, bus.in_right});
        end
    end

    always @(negedge clk27) begin
        check("level", 32'(bus.level), 32'(mq.size()));
        check("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
        check("underrun", 32'(bus.underrun), 32'(m_und));
        check("out_strobe", 32'(bus.out_strobe), 32'(m_stb));
        check("hold_pair", {bus.out_left, bus.out_right}, {m_l, m_r});
        if (bus.out_strobe) begin
            if (exp_q.size() == 0) begin
                check("strobe_without_expected", 32'(1), 32'(0));
            end else begin
                m_p = exp_q.pop_front();
                check("sb_pair", {bus.out_left, bus.out_right}, m_p);
            end
        end
    end

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge clk27);
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        logic ok;
        bus.in_valid = 1'b1;
        bus.in_left  = l;
        bus.in_right = r;
        for (int unsigned i = 0; i < 100; i++) begin
            ok = bus.in_ready;
            @(negedge clk27);
            if (ok) return;
        end
        check("send_timeout", 32'(1), 32'(0));
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_left      = '0;
        bus.in_right     = '0;
        bus.clr_underrun = 1'b0;
        n_rst            = 1'b0;
        idle(5);
        n_rst = 1'b1;

        // Idle: first ticks find the FIFO empty
        idle(8);
        check("idle_underrun", 32'(bus.underrun), 32'(1));
        bus.clr_underrun = 1'b1;
        idle(1);
        bus.clr_underrun = 1'b0;

        // Single directed pair
        send(16'h1234, 16'hEDCB);
        bus.in_valid = 1'b0;
        idle(6);

        // Continuous stream across pointer wrap
        for (int unsigned k = 1; k <= 20; k++) send(16'(k), 16'(k + 16'h100));
        bus.in_valid = 1'b0;

        // Last pair before underrun, then miss ticks
        send(16'h7FFF, 16'h8000);
        bus.in_valid = 1'b0;
        idle(4 * DEPTH + 2 * DIV + 2);
        check("hold_left_7fff", 32'(bus.out_left), 32'h7FFF);
        check("hold_right_8000", 32'(bus.out_right), 32'h8000);

        // Clear alone, away from a tick
        for (int unsigned i = 0; i < 2 * DIV && m_cyc != 0; i++) idle(1);
        bus.clr_underrun = 1'b1;
        idle(1);
        bus.clr_underrun = 1'b0;
        check("clr_alone", 32'(bus.underrun), 32'(0));

        // Clear coinciding with an empty tick: set wins
        for (int unsigned i = 0; i < 2 * DIV && m_cyc != DIV - 1; i++) idle(1);
        bus.clr_underrun = 1'b1;
        idle(1);
        bus.clr_underrun = 1'b0;
        check("clr_vs_set", 32'(bus.underrun), 32'(1));

        // Randomised traffic
        for (int unsigned i = 0; i < 400; i++) begin
            bus.in_valid     = ($urandom_range(0, 3) != 0);
            bus.in_left      = 16'($urandom);
            bus.in_right     = 16'($urandom);
            bus.clr_underrun = ($urandom_range(0, 15) == 0);
            idle(1);
        end
        bus.in_valid     = 1'b0;
        bus.clr_underrun = 1'b0;

        // Mid-stream asynchronous reset
        for (int unsigned k = 0; k < 3; k++) send(16'hA000 + 16'(k), 16'h5000 + 16'(k));
        bus.in_valid = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        check("async_rst_left", 32'(bus.out_left), 32'(0));
        check("async_rst_right", 32'(bus.out_right), 32'(0));
        check("async_rst_level", 32'(bus.level), 32'(0));
        check("async_rst_underrun", 32'(bus.underrun), 32'(0));
        idle(3);
        n_rst = 1'b1;
        idle(2);
        send(16'h0BAD, 16'hF00D);
        send(16'h0CAB, 16'hBEEF);
        bus.in_valid = 1'b0;
        idle(4 * DIV);
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dac_sample_pacer.md
Name: dac_sample_pacer

Overview:
- Upstream feeder for dac_top's sigma-delta modulators: buffers stereo PCM samples from the producer and presents a new left/right pair at a fixed sample rate derived from clk27.
- Valid/ready on input; held sample pair plus one-cycle update strobe on output.
- Underrun is flagged and the last sample is held, so the modulator input never becomes undefined.

Parameters:
- WIDTH, 16, sample width in bits, signed two's complement.
- DEPTH, 8, FIFO depth in sample pairs; power of two, >= 2.
- DIV, 562, clk27 cycles per output sample (27 MHz / 562 ≈ 48.04 kHz); >= 2.

Ports:
- clk27  in  1  system clock, 27 MHz.
- n_rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  producer has a sample pair.
- in_ready  out  1  FIFO can accept; equals !full.
- in_left  in  WIDTH  left sample.
- in_right  in  WIDTH  right sample.
- out_left  out  WIDTH  current left sample to modulator.
- out_right  out  WIDTH  current right sample to modulator.
- out_strobe  out  1  one-cycle pulse, high in the cycle out_* first shows a new pair.
- level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- underrun  out  1  sticky: a tick found the FIFO empty.
- clr_underrun  in  1  clears underrun.

Behaviour:
- Reset (async assert, sync release on clk27):
  - divider = 0, FIFO empty, level = 0.
  - out_left = out_right = 0, out_strobe = 0, underrun = 0.
  - in_ready = 1 from the first clock after release.
  - Reset mid-operation flushes all FIFO contents; no partial state survives.
- Divider:
  - Counts 0..DIV-1 and wraps.
  - Internal tick is asserted for the single cycle where divider == DIV-1.
  - First tick after reset is at cycle DIV-1.
- Push: in_valid && in_ready at a rising edge writes {in_left, in_right} at the write pointer. Pointers wrap modulo DEPTH.
- Pop on tick with level > 0:
  - The head pair is registered into out_left/out_right at that edge.
  - out_strobe = 1 in the following cycle only, coincident with the new out_* values. Latency from tick to visible data is 1 clock.
- Tick with level == 0:
  - out_* hold their previous values.
  - out_strobe stays 0.
  - underrun is set at that edge.
- Simultaneous push and pop:
  - Both take effect and level is unchanged.
  - Pushing into an empty FIFO in the tick cycle does not satisfy that tick; it counts as underrun (no fall-through).
- Full: in_ready = 0 when level == DEPTH. A pop in that cycle does not raise in_ready combinationally; in_ready rises the next cycle.
- underrun clear:
  - clr_underrun clears the flag at the next edge.
  - If clr_underrun and a new underrun event coincide, set wins (underrun stays 1).
- level: registered, updated the same edge as the push/pop, never exceeds DEPTH.
- Arithmetic: no scaling or conversion; samples pass bit-exact.

Test Plan:
- DIV=4, DEPTH=4; reset held 5 cycles, then release, no input -> out_left/out_right = 0 and out_strobe = 0 throughout; underrun = 1 after cycle 3 post-release; in_ready = 1.
- Push (0x1234, 0xEDCB) once, then wait -> at the next tick out_left = 0x1234, out_right = 0xEDCB, with out_strobe high for exactly 1 cycle; level goes 1 -> 0.
- Continuous in_valid with values 1,2,3,4,5… -> in_ready drops after 4 accepted pushes (level = 4); output sequence is 1,2,3,4,… in order, one per 4 cycles; no loss or duplication across pointer wrap (run 20 samples).
- FIFO full and a tick occurs -> level 4 -> 3 and in_ready rises the following cycle; a push in the same cycle as a pop keeps level constant.
- Underrun then recovery: drain the FIFO, miss 2 ticks -> out_* hold the last value (e.g. 0x7FFF/0x8000), underrun = 1; pulse clr_underrun alone -> underrun = 0; clr_underrun coinciding with an empty tick -> underrun stays 1.
- Assert n_rst mid-stream with level = 3 -> out_* = 0, level = 0, underrun = 0 immediately (asynchronous); after release the first strobe appears only after new pushes, at divider == DIV-1 + 1.
